// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run controller.
// Optional feature macro: RUN_CTRL_STEP_EN adds the PAUSE state used for single-stepping.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
`ifdef RUN_CTRL_STEP_EN
      ST_PAUSE = 2'd3,
`endif
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REASON_NONE  = 2'b00,
      REASON_LIMIT = 2'b01,
      REASON_HALT  = 2'b10,
      REASON_ABORT = 2'b11
   } reason_t;

   localparam int          DEFAULT_CNT_W      = 16;
   localparam logic [15:0] DEFAULT_HALT_INSTR = 16'hFFFF;

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: control/observation bundle between the system side and run_ctrl.
// Optional feature macro: RUN_CTRL_STEP_EN adds the step_mode/step signals.
interface run_ctrl_if
   import run_ctrl_pkg::*;
   #(parameter int CNT_W = DEFAULT_CNT_W);

   logic             start;
   logic             abort;
   logic [CNT_W-1:0] max_instr;
   logic             core_done;
   logic [15:0]      instruction;
`ifdef RUN_CTRL_STEP_EN
   logic             step_mode;
   logic             step;
`endif
   logic             run;
   logic             busy;
   logic             finished;
   logic [1:0]       halt_reason;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output start, abort, max_instr, core_done, instruction,
`ifdef RUN_CTRL_STEP_EN
      output step_mode, step,
`endif
      input  run, busy, finished, halt_reason, instr_count
   );

   modport slave (
      input  start, abort, max_instr, core_done, instruction,
`ifdef RUN_CTRL_STEP_EN
      input  step_mode, step,
`endif
      output run, busy, finished, halt_reason, instr_count
   );

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter: CNT_W-bit up counter with synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   // Count enabled cycles, clearing on reset or clear, and never wrapping past all-ones.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: launches the core on start, holds run high while executing, counts
// retirements and stops on instruction limit, halt instruction or abort.
// Optional feature macro: RUN_CTRL_STEP_EN enables step_mode/step single-stepping.
module run_ctrl
   import run_ctrl_pkg::*;
   #(
   parameter int          CNT_W      = DEFAULT_CNT_W,
   parameter logic [15:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
   input  logic     clk,
   input  logic     reset,
   run_ctrl_if.slave bus
);

   state_t           state;
   reason_t          reason_q;
   logic [CNT_W-1:0] limit_q;
   logic [CNT_W-1:0] count_plus;
   logic             run_q;
   logic             busy_q;
   logic             finished_q;
   logic             accept;
   logic             retire;
   logic             hit_limit;
   logic             is_halt;
`ifdef RUN_CTRL_STEP_EN
   logic             step_mode_q;
`endif

   // A retirement only counts while the core is actually running; a start only
   // counts from IDLE. The limit test uses the pre-increment count plus one, so a
   // saturated count never matches a nonzero limit.
   assign accept     = (state == ST_IDLE) && bus.start;
   assign retire     = (state == ST_RUN) && bus.core_done;
   assign count_plus = bus.instr_count + 1'b1;
   assign hit_limit  = (limit_q != '0) && (count_plus == limit_q);
   assign is_halt    = (bus.instruction == HALT_INSTR);

   assign bus.run         = run_q;
   assign bus.busy        = busy_q;
   assign bus.finished    = finished_q;
   assign bus.halt_reason = reason_q;

   sat_counter #(.CNT_W(CNT_W)) u_count (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .enable (retire),
      .count  (bus.instr_count)
   );

   // Run sequencing FSM with registered run/busy/finished/halt_reason outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         reason_q    <= REASON_NONE;
         limit_q     <= '0;
         run_q       <= 1'b0;
         busy_q      <= 1'b0;
         finished_q  <= 1'b0;
`ifdef RUN_CTRL_STEP_EN
         step_mode_q <= 1'b0;
`endif
      end else begin
         finished_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  limit_q  <= bus.max_instr;
                  reason_q <= REASON_NONE;
                  busy_q   <= 1'b1;
`ifdef RUN_CTRL_STEP_EN
                  step_mode_q <= bus.step_mode;
                  if (bus.step_mode) begin
                     state <= ST_PAUSE;
                     run_q <= 1'b0;
                  end else begin
                     state <= ST_RUN;
                     run_q <= 1'b1;
                  end
`else
                  state <= ST_RUN;
                  run_q <= 1'b1;
`endif
               end
            end
            ST_RUN: begin
               if (bus.abort) begin
                  state      <= ST_DONE;
                  reason_q   <= REASON_ABORT;
                  run_q      <= 1'b0;
                  finished_q <= 1'b1;
               end else if (bus.core_done && is_halt) begin
                  state      <= ST_DONE;
                  reason_q   <= REASON_HALT;
                  run_q      <= 1'b0;
                  finished_q <= 1'b1;
               end else if (bus.core_done && hit_limit) begin
                  state      <= ST_DONE;
                  reason_q   <= REASON_LIMIT;
                  run_q      <= 1'b0;
                  finished_q <= 1'b1;
`ifdef RUN_CTRL_STEP_EN
               end else if (bus.core_done && step_mode_q) begin
                  state <= ST_PAUSE;
                  run_q <= 1'b0;
`endif
               end
            end
`ifdef RUN_CTRL_STEP_EN
            ST_PAUSE: begin
               if (bus.abort) begin
                  state      <= ST_DONE;
                  reason_q   <= REASON_ABORT;
                  finished_q <= 1'b1;
               end else if (bus.step) begin
                  state <= ST_RUN;
                  run_q <= 1'b1;
               end
            end
`endif
            ST_DONE: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               run_q  <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sequences the fetch/execute core. It launches program execution on a start pulse and holds the core's `run` input high while execution proceeds. It counts retired instructions and stops execution at an instruction limit, a halt instruction, or an abort. It sits between the system/testbench control and the core, driving `run` and observing `core_done` and the current `instruction`.

## Interface
- `CNT_W`, 16: width of the instruction counter and limit.
- `HALT_INSTR`, 16'hFFFF: encoding that terminates execution when it retires.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `start` in 1: single-cycle launch request; ignored unless IDLE.
- `abort` in 1: stop request; honoured in RUN/PAUSE.
- `max_instr` in CNT_W: instruction limit sampled on accepted start; 0 = unlimited.
- `core_done` in 1: core retired one instruction this cycle.
- `instruction` in 16: instruction being executed/retired this cycle.
- `step_mode` in 1 (RUN_CTRL_STEP_EN only): sampled on accepted start.
- `step` in 1 (RUN_CTRL_STEP_EN only): single-cycle pulse; executes one instruction from PAUSE.
- `run` out 1: drive to core; high exactly in state RUN.
- `busy` out 1: state ≠ IDLE.
- `finished` out 1: one-cycle pulse in state DONE.
- `halt_reason` out 2: 00 none, 01 limit, 10 halt instr, 11 abort; held until next accepted start.
- `instr_count` out CNT_W: retired instructions since last accepted start; held after stop.

## Operation
- States: IDLE, RUN, PAUSE (step build only), DONE. All transitions are registered.
- In IDLE, `start` moves to RUN. It clears `instr_count` and `halt_reason` and latches `max_instr`. In IDLE, `abort` is ignored, including when it coincides with `start`.
- In RUN, each cycle with `core_done`=1 is one retirement:
  - If `instruction`==HALT_INSTR: go to DONE with reason 10. The count includes the halt instruction.
  - Else, if the limit is nonzero and count+1 == limit: go to DONE with reason 01.
  - Otherwise stay in RUN.
  - The count increments on every retirement. It saturates at all-ones and never wraps.
- `abort` in RUN or PAUSE goes to DONE with reason 11.
  - Abort takes precedence over halt or limit in the same cycle.
  - The coinciding retirement is still counted.
- An abort mid-instruction leaves the core state undefined. Software must reset the core before the next start.
- DONE lasts exactly one cycle with `finished`=1, then moves to IDLE.
- `start` while busy is ignored.
- `core_done` outside RUN is ignored. It is not counted.

## Timing
- Reset state is IDLE. All outputs reset to 0: `run`, `busy`, `finished`, `halt_reason`, `instr_count`.
- `start` sampled at edge t gives `run`=1 and `busy`=1 from cycle t+1.
- A stopping retirement at edge t gives `run`=0 and `finished`=1 in cycle t+1, and `busy`=0 from t+2.
- `run` drops one cycle after the stopping retirement. The core's own gating (`core_done` requires `run`) prevents a further retirement from being counted.
- `instr_count` updates in the cycle after each retirement edge.
- Minimum start-to-start interval: the run length plus 2 cycles.
- A reset asserted mid-operation returns to IDLE on the next edge with all outputs cleared. No `finished` pulse is produced.

## Configuration
- `RUN_CTRL_STEP_EN` defined:
  - The `step_mode`/`step` ports and the PAUSE state exist.
  - With `step_mode`=1 at start, IDLE→PAUSE (`run`=0, `busy`=1).
  - `step` in PAUSE→RUN. The next retirement returns to PAUSE unless halt/limit/abort sends it to DONE.
  - `step` outside PAUSE is ignored.
- Not defined: the ports and PAUSE are absent, and start always enters RUN.

## Structure
- Package `run_ctrl_pkg`:
  - State enum.
  - `halt_reason` codes: REASON_NONE/LIMIT/HALT/ABORT.
  - Default HALT_INSTR constant.
- Sub-module `sat_counter` (CNT_W-bit, sync clear, enable, saturating) holds `instr_count`. The FSM stays in `run_ctrl`.

## Test plan
- Limit: `max_instr`=3, core retires non-halt instrs every 4 cycles → exactly 3 retirements counted, `halt_reason`=01, `finished` pulse one cycle after 3rd `core_done`, `run` never high afterward.
- Halt: `max_instr`=0, program 16'h0001,16'h0002,16'hFFFF → `instr_count`=3, `halt_reason`=10.
- Abort mid-run: abort in a cycle without `core_done` after 2 retirements → `instr_count`=2, `halt_reason`=11. Abort coinciding with HALT_INSTR retirement → reason 11, count includes it.
- Saturation/ignore: CNT_W=4, `max_instr`=0, 20 retirements → `instr_count`=15. `start` during RUN → no effect. `core_done` in IDLE → count unchanged.
- Reset mid-RUN: assert `reset` one cycle → all outputs 0 next cycle, no `finished` pulse, new `start` works normally.
- Step (RUN_CTRL_STEP_EN): `step_mode`=1, 3 `step` pulses → 3 retirements, PAUSE between each with `run`=0. `step` while RUN ignored.
